// File: rtl/mult_product_control.sv
// Shift-add multiplier sequencer with 2*WIDTH product register.
// Optional MULT_ZERO_SKIP_EN: finish early on a zero operand.
module mult_product_control #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               Run,
  input  logic [WIDTH-1:0]   Multiplier_in,
  input  logic [WIDTH-1:0]   Multiplicand,
  output logic               W_ctrl,
  output logic [2*WIDTH-1:0] Product_out,
  output logic               Ready
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   counter;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     sum;
  logic               last;
  logic               skip;

  assign sum  = {1'b0, product[2*WIDTH-1:WIDTH]}
              + {1'b0, Multiplicand};
  assign last = (counter == CNT_W'(WIDTH-1));

`ifdef MULT_ZERO_SKIP_EN
  assign skip = (counter == '0)
             && ((Multiplicand == '0)
             ||  (product[WIDTH-1:0] == '0));
`else
  assign skip = 1'b0;
`endif

  assign Product_out = product;

  // State register
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; Run only matters in IDLE and DONE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (Run) state_nxt = LOAD;
      LOAD: state_nxt = CALC;
      CALC: if (skip || last) state_nxt = DONE;
      DONE: if (Run) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    W_ctrl = 1'b0;
    Ready  = 1'b0;
    unique case (state)
      LOAD:    W_ctrl = 1'b1;
      DONE:    Ready  = 1'b1;
      default: ;
    endcase
  end

  // Product/counter datapath; carry lands in the top bit
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      product <= '0;
      counter <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          product <= {{WIDTH{1'b0}}, Multiplier_in};
          counter <= '0;
        end
        CALC: begin
          counter <= counter + CNT_W'(1);
          if (skip)
            product <= '0;
          else if (product[0])
            product <= {sum, product[WIDTH-1:1]};
          else
            product <= product >> 1;
        end
        default: ;
      endcase
    end
  end

endmodule
